// File: rtl/video_clk_pkg.sv
// Shared constants and types for the NCO clock-enable synthesiser.
// Exports increment words, lock FSM state type and a channel-index width helper.
package video_clk_pkg;

  localparam int ACC_W_DEF = 32;

  // Increment words for a 50 MHz reference: inc = f_out / f_ref * 2^32.
  localparam logic [31:0] INC_25M = 32'h8000_0000;
  localparam logic [31:0] INC_33M = 32'hA8F5_C28F;

  // An NCO cannot emit more enables than refclk edges, so 65 and 108 MHz
  // are unreachable from 50 MHz; these words assume a 200 MHz refclk.
  localparam logic [31:0] INC_65M = 32'h5333_3333;
  localparam logic [31:0] INC_108M = 32'h8A3D_70A4;

  // ch0 in the LSBs: 25, 25, 33 MHz.
  localparam logic [95:0] DEFAULT_INC_3CH = {
    INC_33M, INC_25M, INC_25M
  };

  typedef enum logic {
    LK_SETTLING,
    LK_LOCKED
  } lock_state_t;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/video_nco_chan.sv
// One NCO channel: phase accumulator, live/staged increment, enable outputs.
// Ports: clk, rst_n, en_i, sync_i, load_i/inc_i (accepted cfg), pending_o, clken_o, outclk_o.
module video_nco_chan
  import video_clk_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter logic [ACC_W-1:0] RST_INC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             load_i,
  input  logic [ACC_W-1:0] inc_i,
  output logic             pending_o,
  output logic             clken_o,
  output logic             outclk_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W-1:0] new_inc_q, new_inc_d;
  logic             pending_q, pending_d;
  logic             clken_q, clken_d;
  logic             outclk_q, outclk_d;
  logic [ACC_W:0]   sum;
  logic             run;
  logic             carry;
  logic             imm;

  assign sum = {1'b0, acc_q} + {1'b0, inc_q};

  always_comb begin
    run       = en_i & ~sync_i;
    acc_d     = run ? sum[ACC_W-1:0] : '0;
    carry     = run & sum[ACC_W];
    clken_d   = carry;
    outclk_d  = acc_d[ACC_W-1];
    inc_d     = inc_q;
    new_inc_d = new_inc_q;
    pending_d = pending_q;
    // No carry would ever arrive to swap on, so take it straight away.
    imm       = ~run | (inc_q == '0);
    if (load_i) begin
      if (imm) begin
        inc_d = inc_i;
      end else begin
        new_inc_d = inc_i;
        pending_d = 1'b1;
      end
    end else if (pending_q & (carry | ~run)) begin
      inc_d     = new_inc_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      inc_q     <= RST_INC;
      new_inc_q <= '0;
      pending_q <= 1'b0;
      clken_q   <= 1'b0;
      outclk_q  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      inc_q     <= inc_d;
      new_inc_q <= new_inc_d;
      pending_q <= pending_d;
      clken_q   <= clken_d;
      outclk_q  <= outclk_d;
    end
  end

  assign pending_o = pending_q;
  assign clken_o   = clken_q;
  assign outclk_o  = outclk_q;

endmodule

// File: rtl/video_clken_synth.sv
// Multi-channel NCO clock-enable synthesiser with runtime retune and lock flag.
// Ports: refclk, rst_n, chan_en_i, sync_i, cfg_* handshake, clken_o, outclk_o, locked_o.
module video_clken_synth
  import video_clk_pkg::*;
#(
  parameter int NUM_CLOCKS = 3,
  parameter int ACC_W = ACC_W_DEF,
  parameter int SETTLE_CYCLES = 1024,
  parameter logic [NUM_CLOCKS*ACC_W-1:0] DEFAULT_INC = DEFAULT_INC_3CH
) (
  input  logic                            refclk,
  input  logic                            rst_n,
  input  logic [NUM_CLOCKS-1:0]           chan_en_i,
  input  logic                            sync_i,
  input  logic                            cfg_valid_i,
  output logic                            cfg_ready_o,
  input  logic [chan_w(NUM_CLOCKS)-1:0]   cfg_chan_i,
  input  logic [ACC_W-1:0]                cfg_inc_i,
  output logic [NUM_CLOCKS-1:0]           clken_o,
  output logic [NUM_CLOCKS-1:0]           outclk_o,
  output logic                            locked_o
);

  localparam int CH_W = chan_w(NUM_CLOCKS);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  logic [1:0]            rst_sync_q, rst_sync_d;
  logic                  rst_int_n;
  logic                  live_q, live_d;
  logic [NUM_CLOCKS-1:0] pending;
  logic [NUM_CLOCKS-1:0] load_vec;
  logic                  chan_ok;
  logic                  chan_pend;
  logic                  accept;
  logic                  any_pend;

  lock_state_t           state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  locked_q;

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
    live_d     = rst_sync_q[0];
  end

  // live_q mirrors rst_sync_q[1] so the reset net never feeds data logic.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
      live_q     <= 1'b0;
    end else begin
      rst_sync_q <= rst_sync_d;
      live_q     <= live_d;
    end
  end

  assign rst_int_n = rst_sync_q[1];

  always_comb begin
    chan_ok   = 1'b0;
    chan_pend = 1'b0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      if (cfg_chan_i == CH_W'(i)) begin
        chan_ok   = 1'b1;
        chan_pend = pending[i];
      end
    end
    cfg_ready_o = live_q & chan_ok & ~chan_pend;
    accept      = cfg_valid_i & cfg_ready_o;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      load_vec[i] = accept & (cfg_chan_i == CH_W'(i));
    end
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
    video_nco_chan #(
      .ACC_W   (ACC_W),
      .RST_INC (DEFAULT_INC[i*ACC_W +: ACC_W])
    ) u_chan (
      .clk       (refclk),
      .rst_n     (rst_int_n),
      .en_i      (chan_en_i[i]),
      .sync_i    (sync_i),
      .load_i    (load_vec[i]),
      .inc_i     (cfg_inc_i),
      .pending_o (pending[i]),
      .clken_o   (clken_o[i]),
      .outclk_o  (outclk_o[i])
    );
  end

  assign any_pend = |pending;

  always_ff @(posedge refclk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q  <= LK_SETTLING;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      unique case (state_q)
        LK_SETTLING: begin
          if (any_pend | accept) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            state_q  <= LK_LOCKED;
            locked_q <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        LK_LOCKED: begin
          if (accept) begin
            state_q  <= LK_SETTLING;
            locked_q <= 1'b0;
            cnt_q    <= '0;
          end
        end
      endcase
    end
  end

  assign locked_o = locked_q;

endmodule

// File: tb/tb_video_clken_synth.sv
// Randomised self-checking bench for video_clken_synth.
// Reference model: per-channel phase in 64-bit arithmetic, lock = quiet-cycle run length.
module tb_video_clken_synth;
  import video_clk_pkg::*;

  localparam int N = 3;
  localparam int AW = 32;
  localparam int SETTLE = 1024;
  localparam longint MOD = 64'h1_0000_0000;
  localparam logic [N*AW-1:0] DEF = {
    32'hA8F5_C28F, 32'h8000_0000, 32'h8000_0000
  };

  logic          refclk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  chan_en_i;
  logic          sync_i;
  logic          cfg_valid_i;
  logic          cfg_ready_o;
  logic [1:0]    cfg_chan_i;
  logic [AW-1:0] cfg_inc_i;
  logic [N-1:0]  clken_o;
  logic [N-1:0]  outclk_o;
  logic          locked_o;

  int checks = 0;
  int failures = 0;

  longint       m_acc[N];
  longint       m_inc[N];
  longint       m_new[N];
  bit           m_pend[N];
  bit [N-1:0]   m_clken;
  bit [N-1:0]   m_outclk;
  int           m_quiet;
  int           m_rs;

  video_clken_synth dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .chan_en_i   (chan_en_i),
    .sync_i      (sync_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_chan_i  (cfg_chan_i),
    .cfg_inc_i   (cfg_inc_i),
    .clken_o     (clken_o),
    .outclk_o    (outclk_o),
    .locked_o    (locked_o)
  );

  always #10 refclk = ~refclk;

  function automatic bit m_ready(input logic [1:0] ch);
    if (m_rs < 2 || ch >= N) return 1'b0;
    return !m_pend[ch];
  endfunction

  function automatic logic [2*N:0] m_out();
    return {m_clken, m_outclk, m_quiet >= SETTLE};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_acc[i] = 0;
      m_inc[i] = longint'(DEF[i*AW +: AW]);
      m_new[i] = 0;
      m_pend[i] = 1'b0;
    end
    m_clken = '0;
    m_outclk = '0;
    m_quiet = 0;
    m_rs = 0;
  endtask

  // Advance one refclk edge, updating the model from the inputs seen there.
  task automatic tick();
    logic [N-1:0] en;
    logic sy;
    logic [1:0] ch;
    longint ninc, sum;
    bit hit, busy, run, carry;
    en = chan_en_i;
    sy = sync_i;
    ch = cfg_chan_i;
    ninc = longint'(cfg_inc_i);
    hit = cfg_valid_i && m_ready(ch);
    busy = hit;
    for (int i = 0; i < N; i++) busy |= m_pend[i];
    @(posedge refclk);
    if (!rst_n) begin
      m_reset();
    end else if (m_rs < 2) begin
      m_rs++;
    end else begin
      m_quiet = busy ? 0 : m_quiet + 1;
      for (int i = 0; i < N; i++) begin
        run = en[i] && !sy;
        sum = m_acc[i] + m_inc[i];
        carry = run && (sum >= MOD);
        if (hit && ch == i) begin
          if (!run || m_inc[i] == 0) begin
            m_inc[i] = ninc;
          end else begin
            m_new[i] = ninc;
            m_pend[i] = 1'b1;
          end
        end else if (m_pend[i] && (carry || !run)) begin
          m_inc[i] = m_new[i];
          m_pend[i] = 1'b0;
        end
        m_acc[i] = run ? sum % MOD : 0;
        m_clken[i] = carry;
        m_outclk[i] = m_acc[i] >= MOD / 2;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({clken_o, outclk_o, locked_o, cfg_ready_o} !== 8'h00) begin
        failures++;
        $display("FAIL reset_hold got=%b exp=0",
                 {clken_o, outclk_o, locked_o, cfg_ready_o});
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (cfg_ready_o !== (k == 1)) begin
        failures++;
        $display("FAIL reset_ready k=%0d got=%b exp=%b",
                 k, cfg_ready_o, k == 1);
      end
    end
  endtask

  task automatic test_defaults();
    int n0, n2, first_lock;
    n0 = 0;
    n2 = 0;
    first_lock = 0;
    for (int k = 1; k <= 1100; k++) begin
      tick();
      checks++;
      if ({clken_o, outclk_o, locked_o} !== m_out()) begin
        failures++;
        $display("FAIL defaults cyc=%0d got=%b exp=%b",
                 k, {clken_o, outclk_o, locked_o}, m_out());
      end
      if (k <= 1000 && clken_o[0]) n0++;
      if (k > 1000 && k <= 1050 && clken_o[2]) n2++;
      if (locked_o && first_lock == 0) first_lock = k;
    end
    checks++;
    if (n0 != 500) begin
      failures++;
      $display("FAIL ch0_rate got=%0d exp=500", n0);
    end
    checks++;
    if (n2 < 32 || n2 > 34) begin
      failures++;
      $display("FAIL ch2_rate got=%0d exp=33+-1", n2);
    end
    checks++;
    if (first_lock != SETTLE) begin
      failures++;
      $display("FAIL lock_time got=%0d exp=%0d", first_lock, SETTLE);
    end
  endtask

  task automatic test_retune();
    int n2;
    cfg_chan_i = 2'd2;
    cfg_inc_i = 32'h4000_0000;
    cfg_valid_i = 1'b1;
    #1;
    checks++;
    if (cfg_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL retune_ready got=%b exp=1", cfg_ready_o);
    end
    tick();
    cfg_valid_i = 1'b0;
    checks++;
    if (locked_o !== 1'b0) begin
      failures++;
      $display("FAIL retune_unlock got=%b exp=0", locked_o);
    end
    n2 = 0;
    for (int k = 0; k < 1200; k++) begin
      tick();
      checks++;
      if ({clken_o, outclk_o, locked_o} !== m_out()) begin
        failures++;
        $display("FAIL retune cyc=%0d got=%b exp=%b",
                 k, {clken_o, outclk_o, locked_o}, m_out());
      end
      if (k >= 30 && k < 70 && clken_o[2]) n2++;
    end
    checks++;
    if (n2 != 10) begin
      failures++;
      $display("FAIL retune_period got=%0d exp=10", n2);
    end
    checks++;
    if (locked_o !== 1'b1) begin
      failures++;
      $display("FAIL retune_relock got=%b exp=1", locked_o);
    end
  endtask

  task automatic test_back_to_back();
    bit done;
    cfg_chan_i = 2'd2;
    cfg_inc_i = INC_33M;
    cfg_valid_i = 1'b1;
    #1;
    checks++;
    if (cfg_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first got=%b exp=1", cfg_ready_o);
    end
    tick();
    cfg_inc_i = 32'h2000_0000;
    #1;
    checks++;
    if (cfg_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_busy got=%b exp=0", cfg_ready_o);
    end
    cfg_chan_i = 2'd0;
    cfg_inc_i = 32'h8000_0000;
    #1;
    checks++;
    if (cfg_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b_other got=%b exp=1", cfg_ready_o);
    end
    tick();
    cfg_chan_i = 2'd2;
    cfg_inc_i = 32'h2000_0000;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      checks++;
      if (cfg_ready_o !== m_ready(2'd2)) begin
        failures++;
        $display("FAIL b2b_wait k=%0d got=%b exp=%b",
                 k, cfg_ready_o, m_ready(2'd2));
      end
      done = m_ready(2'd2);
      tick();
      checks++;
      if ({clken_o, outclk_o, locked_o} !== m_out()) begin
        failures++;
        $display("FAIL b2b k=%0d got=%b exp=%b",
                 k, {clken_o, outclk_o, locked_o}, m_out());
      end
    end
    cfg_valid_i = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL b2b_timeout got=0 exp=1");
    end
  endtask

  task automatic test_disable();
    chan_en_i = 3'b101;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({clken_o, outclk_o, locked_o} !== m_out()) begin
        failures++;
        $display("FAIL dis k=%0d got=%b exp=%b",
                 k, {clken_o, outclk_o, locked_o}, m_out());
      end
    end
    checks++;
    if ({clken_o[1], outclk_o[1]} !== 2'b00) begin
      failures++;
      $display("FAIL dis_out got=%b exp=00", {clken_o[1], outclk_o[1]});
    end
    cfg_chan_i = 2'd1;
    cfg_inc_i = 32'hC000_0000;
    cfg_valid_i = 1'b1;
    #1;
    tick();
    cfg_valid_i = 1'b0;
    checks++;
    if (cfg_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL dis_applied got=%b exp=1", cfg_ready_o);
    end
    chan_en_i = 3'b111;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if ({clken_o, outclk_o, locked_o} !== m_out()) begin
        failures++;
        $display("FAIL reen k=%0d got=%b exp=%b",
                 k, {clken_o, outclk_o, locked_o}, m_out());
      end
      if (k < 2) begin
        checks++;
        if (clken_o[1] !== (k == 1)) begin
          failures++;
          $display("FAIL reen_first k=%0d got=%b exp=%b",
                   k, clken_o[1], k == 1);
        end
      end
    end
  endtask

  task automatic test_sync();
    bit done;
    int pre;
    cfg_chan_i = 2'd2;
    cfg_inc_i = INC_33M;
    cfg_valid_i = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      done = m_ready(2'd2);
      tick();
    end
    cfg_valid_i = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL sync_cfg_timeout got=0 exp=1");
    end
    pre = 10 + $urandom_range(0, 20);
    for (int k = 0; k < pre; k++) begin
      tick();
      checks++;
      if ({clken_o, outclk_o, locked_o} !== m_out()) begin
        failures++;
        $display("FAIL sync_pre k=%0d got=%b exp=%b",
                 k, {clken_o, outclk_o, locked_o}, m_out());
      end
    end
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    checks++;
    if ({clken_o, outclk_o[0], outclk_o[2]} !== 5'b0) begin
      failures++;
      $display("FAIL sync_zero got=%b exp=0",
               {clken_o, outclk_o[0], outclk_o[2]});
    end
    tick();
    checks++;
    if ({outclk_o[0], outclk_o[2]} !== 2'b11) begin
      failures++;
      $display("FAIL sync_align got=%b exp=11",
               {outclk_o[0], outclk_o[2]});
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if ({clken_o, outclk_o, locked_o} !== m_out()) begin
        failures++;
        $display("FAIL sync_post k=%0d got=%b exp=%b",
                 k, {clken_o, outclk_o, locked_o}, m_out());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      chan_en_i = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b111;
      sync_i = ($urandom_range(0, 31) == 0);
      cfg_valid_i = ($urandom_range(0, 5) == 0);
      cfg_chan_i = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: cfg_inc_i = '0;
        1: cfg_inc_i = 32'h8000_0000;
        default: cfg_inc_i = $urandom;
      endcase
      #1;
      checks++;
      if (cfg_ready_o !== m_ready(cfg_chan_i)) begin
        failures++;
        $display("FAIL rnd_ready k=%0d ch=%0d got=%b exp=%b",
                 k, cfg_chan_i, cfg_ready_o, m_ready(cfg_chan_i));
      end
      tick();
      checks++;
      if ({clken_o, outclk_o, locked_o} !== m_out()) begin
        failures++;
        $display("FAIL rnd k=%0d got=%b exp=%b",
                 k, {clken_o, outclk_o, locked_o}, m_out());
      end
    end
    chan_en_i = 3'b111;
    sync_i = 1'b0;
    cfg_valid_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit done;
    int n2;
    cfg_chan_i = 2'd2;
    for (int pass = 0; pass < 2; pass++) begin
      cfg_inc_i = (pass == 0) ? INC_33M : 32'h4000_0000;
      cfg_valid_i = 1'b1;
      done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
        #1;
        done = m_ready(2'd2);
        tick();
      end
      cfg_valid_i = 1'b0;
      checks++;
      if (!done) begin
        failures++;
        $display("FAIL rstmid_cfg pass=%0d got=0 exp=1", pass);
      end
    end
    checks++;
    if (cfg_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_pending got=%b exp=0", cfg_ready_o);
    end
    #5;
    rst_n = 1'b0;
    #1;
    m_reset();
    checks++;
    if ({clken_o, outclk_o, locked_o, cfg_ready_o} !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_async got=%b exp=0",
               {clken_o, outclk_o, locked_o, cfg_ready_o});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n2 = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      checks++;
      if ({clken_o, outclk_o, locked_o} !== m_out()) begin
        failures++;
        $display("FAIL rstmid k=%0d got=%b exp=%b",
                 k, {clken_o, outclk_o, locked_o}, m_out());
      end
      if (k >= 10 && clken_o[2]) n2++;
    end
    checks++;
    if (n2 < 32 || n2 > 34) begin
      failures++;
      $display("FAIL rstmid_rate got=%0d exp=33+-1", n2);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    chan_en_i = 3'b111;
    sync_i = 1'b0;
    cfg_valid_i = 1'b0;
    cfg_chan_i = 2'd0;
    cfg_inc_i = '0;
    m_reset();
    #2;
    test_reset();
    test_defaults();
    test_retune();
    test_back_to_back();
    test_disable();
    test_sync();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
